// File: rtl/uart_loop_pkg.sv
// Shared types and constants for the UART loopback controller.
package uart_loop_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    REQ       = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  localparam int         DEF_DEPTH = 4;
  localparam logic [7:0] DEF_INC   = 8'd1;
  localparam logic [7:0] MASK7     = 8'h7F;

  // Increment mod 256, then clear bit 7 for 7-bit framing.
  function automatic logic [7:0] fmt_byte(input logic [7:0] b, input logic [7:0] inc,
                                          input logic d_num);
    logic [7:0] sum;
    sum = b + inc;
    return d_num ? sum : (sum & MASK7);
  endfunction

endpackage

// File: rtl/loop_fifo.sv
// Small synchronous FIFO; when full, a pop in the same cycle frees the slot for a push.
module loop_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == LW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_loop_ctrl.sv
// UART RX->TX loopback: sync/edge-detect RX strobe, buffer, add INC, hand to TX.
// Optional error dropping enabled by defining UART_LOOP_ERR_DROP_EN.
module uart_loop_ctrl
  import uart_loop_pkg::*;
#(
  parameter int         DEPTH = DEF_DEPTH,
  parameter logic [7:0] INC   = DEF_INC,
  parameter int         LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  input  logic          rx_error,
  input  logic          d_num,
  input  logic          tx_ready,
  output logic [7:0]    data_out,
  output logic          send_flag,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  output logic [7:0]    err_cnt
);
  logic       rx_s1_q, rx_s2_q, rx_prev_q;
  logic       tx_s1_q, tx_s2_q;
  logic       rx_edge, push, pop, full, empty;
  logic [7:0] head;
  tx_state_e  state_q, state_d;
  logic [7:0] data_out_q, data_out_d;
  logic       send_flag_q, send_flag_d;
  logic       overflow_q, overflow_d;

  assign rx_edge = rx_s2_q & ~rx_prev_q;

`ifdef UART_LOOP_ERR_DROP_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  assign push      = rx_edge & ~rx_error;
  assign err_cnt_d = (rx_edge && rx_error && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  assign err_cnt   = err_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end
`else
  logic unused_rx_error;
  assign unused_rx_error = rx_error;
  assign push            = rx_edge;
  assign err_cnt         = 8'h00;
`endif

  loop_fifo #(.DEPTH(DEPTH), .W(8), .LW(LW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rx_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // A byte is lost only if the FIFO is full and nothing leaves this cycle.
  assign overflow_d = overflow_q | (push & full & ~pop);

  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (!empty && tx_s2_q) begin
        state_d    = LOAD;
        pop        = 1'b1;
        data_out_d = fmt_byte(head, INC, d_num);
      end
      LOAD:      state_d = REQ;
      REQ:       if (!tx_s2_q) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_s2_q)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    send_flag_d = (state_d == REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q     <= 1'b0;
      rx_s2_q     <= 1'b0;
      rx_prev_q   <= 1'b0;
      tx_s1_q     <= 1'b0;
      tx_s2_q     <= 1'b0;
      state_q     <= IDLE;
      data_out_q  <= 8'h00;
      send_flag_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rx_s1_q     <= rx_ready;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      tx_s1_q     <= tx_ready;
      tx_s2_q     <= tx_s1_q;
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      send_flag_q <= send_flag_d;
      overflow_q  <= overflow_d;
    end
  end

  assign data_out  = data_out_q;
  assign send_flag = send_flag_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/uart_loop_ctrl.md
# uart_loop_ctrl

Loopback controller between the UART receiver and the UART transmitter in the counter-loop design. Captures each received byte on the receiver's ready strobe, buffers it in a small FIFO, adds a fixed increment, and hands the result to the transmitter through a request/busy handshake. It runs on the system clock and synchronizes the receiver's and transmitter's divided-clock status signals internally.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- INC, 8'd1, value added to every forwarded byte (mod 256)

- clk  in  1  system clock (undivided)
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  receiver buffer output; stable while rx_ready high
- rx_ready  in  1  receiver byte-valid level (RX clock domain)
- rx_error  in  1  receiver framing/parity error, valid with rx_ready
- d_num  in  1  data length select: 0 = 7 bits, 1 = 8 bits
- tx_ready  in  1  transmitter idle (TX clock domain); low while a frame is sent
- data_out  out  8  byte presented to transmitter
- send_flag  out  1  active-high send request
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a byte was lost because the FIFO was full
- err_cnt  out  8  count of errored bytes dropped, saturating at 255

## Operation
- rx_ready and tx_ready each pass through a 2-flop synchronizer; rx_ready rising edge is detected on the synchronized copy (one push per edge, regardless of high duration).
- On a detected edge: rx_data sampled, pushed with rx_error bit (see Configuration).
- FIFO full on push: byte discarded, overflow set; cleared only by rst. Push and pop in the same cycle while full: pop frees the slot, push accepted.
- TX FSM states: IDLE, LOAD, REQ, WAIT_DONE.
  - IDLE: FIFO non-empty and tx_ready_s high → LOAD; pop head; data_out ← (head + INC) mod 256, bit 7 forced 0 when d_num = 0 (d_num sampled at this edge).
  - LOAD → REQ unconditionally.
  - REQ: send_flag = 1; hold until tx_ready_s = 0 → WAIT_DONE.
  - WAIT_DONE: send_flag = 0; tx_ready_s = 1 → IDLE.
- send_flag is registered, high exactly while state = REQ. data_out stays constant from LOAD until the next LOAD.
- No timeout in REQ: request held indefinitely.

## Timing
- Reset values: data_out 8'h00, send_flag 0, fifo_level 0, overflow 0, err_cnt 0, FSM IDLE, synchronizers 0.
- rst asserted mid-operation: all state cleared immediately, including an outstanding request; buffered bytes lost.
- Latency (empty FIFO, IDLE, tx_ready high): rx_ready first sampled high at edge 1 → push at edge 3 → LOAD at edge 4 → send_flag high after edge 5.
- rx_data must be stable ≥3 clk cycles after rx_ready rises; guaranteed by the divided RX clock.
- Back-to-back bytes: the minimum gap between send_flag pulses is the transmitter frame time plus 4 clk cycles (sync + IDLE + LOAD).

## Configuration
- UART_LOOP_ERR_DROP_EN defined: bytes arriving with rx_error = 1 are not pushed; err_cnt increments (saturating); overflow is unaffected.
- Undefined: rx_error is ignored; every byte is forwarded normally; err_cnt is tied to 0.

## Structure
- Package uart_loop_pkg: FSM state enum (IDLE, LOAD, REQ, WAIT_DONE), default DEPTH, default INC, 7-bit mask constant 8'h7F.
- Sub-module loop_fifo: synchronous FIFO with push/pop/full/empty/level and the full-with-simultaneous-pop rule. Synchronizers, edge detect, FSM, and counters live in uart_loop_ctrl.

## Test plan
- Single byte: rx_data 8'h41, d_num 1, one rx_ready pulse → send_flag rises after edge 5 with data_out 8'h42; drops after tx_ready falls.
- 7-bit wrap: rx_data 8'h7F, d_num 0 → data_out 8'h00. With d_num 1, rx_data 8'hFF → data_out 8'h00.
- Overflow: hold tx_ready low, send 5 bytes 8'h10..8'h14 → fifo_level 4, overflow 1; release tx_ready → output is 8'h11..8'h14 in order, and 8'h15 never appears.
- Error drop (macro on): rx_error 1 with byte 8'h20 → no send_flag, err_cnt 1. Macro off: data_out 8'h21 is sent.
- Reset mid-request: assert rst while send_flag 1 and 2 bytes are queued → send_flag 0 and fifo_level 0 immediately; after release, there is no further send_flag without new input.
- Handshake hold: send_flag asserted with tx_ready held high for 100 cycles → send_flag stays high and data_out is unchanged until tx_ready falls.
